// File: rtl/snn_pkg.sv
// Shared types for the SNN batch scheduler: FSM states and class encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_pkg;

  // Sequencer states, one engine at a time
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENG_RST = 3'd1,
    LAUNCH  = 3'd2,
    WAIT    = 3'd3,
    NEXT    = 3'd4,
    FLUSH   = 3'd5
  } sched_state_e;

  // predicted_class encodings reported by each engine
  localparam logic CLASS_STRAIGHT = 1'b0;
  localparam logic CLASS_TURN     = 1'b1;

  // Width of the reset-hold counter (hold length 1..15)
  localparam int RST_HOLD_W = 4;

  // Index width that stays legal for a single-engine build
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_watchdog.sv
// Per-engine wait counter: counts cycles in WAIT and flags when TIMEOUT is reached.
// Latency: expired_o is a registered-count compare, valid the cycle the count hits TIMEOUT.
// Backpressure: none; load has priority over enable, count saturates at TIMEOUT.
module snn_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load zeroes, enable advances until the limit and then holds
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/snn_batch_scheduler.sv
// Sequences a batch over NUM_ENGINES engines: reset, start, wait for done or timeout, record class.
// Latency: per engine RST_HOLD + 1 (launch) + wait + 1 (next) cycles; busy rises the cycle after accept.
// Backpressure: batch_start ignored while busy; abort preempts everything outside IDLE.
module snn_batch_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_ENGINES = 20,
  parameter int RST_HOLD    = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               batch_start,
  input  logic                               abort,
  output logic                               eng_rst,
  output logic [NUM_ENGINES-1:0]             eng_start,
  input  logic [NUM_ENGINES-1:0]             eng_done,
  input  logic [NUM_ENGINES-1:0]             eng_class,
  output logic                               busy,
  output logic                               batch_done,
  output logic [NUM_ENGINES-1:0]             results,
  output logic [NUM_ENGINES-1:0]             timeout_mask,
  output logic [$clog2(NUM_ENGINES+1)-1:0]   turn_count
);

  localparam int IDX_W = idx_width(NUM_ENGINES);
  localparam int TC_W  = $clog2(NUM_ENGINES + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_ENGINES - 1);
  localparam logic [RST_HOLD_W-1:0] HOLD_INIT = RST_HOLD_W'(RST_HOLD - 1);

  sched_state_e           state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [RST_HOLD_W-1:0]  hold_q;
  logic                   eng_rst_q;
  logic [NUM_ENGINES-1:0] eng_start_q;
  logic                   busy_q;
  logic                   batch_done_q;
  logic [NUM_ENGINES-1:0] results_q;
  logic [NUM_ENGINES-1:0] timeout_mask_q;
  logic [TC_W-1:0]        turn_count_q;

  logic wd_load;
  logic wd_en;
  logic wd_expired;

  // Watchdog is zeroed while the start pulse is out and runs only while waiting
  assign wd_load = (state_q == LAUNCH);
  assign wd_en   = (state_q == WAIT);

  snn_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (wd_load),
    .enable_i  (wd_en),
    .expired_o (wd_expired)
  );

  // Sequencer FSM with registered outputs; abort outranks every other event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      hold_q         <= '0;
      eng_rst_q      <= 1'b1;
      eng_start_q    <= '0;
      busy_q         <= 1'b0;
      batch_done_q   <= 1'b0;
      results_q      <= '0;
      timeout_mask_q <= '0;
      turn_count_q   <= '0;
    end else begin
      batch_done_q <= 1'b0;
      eng_start_q  <= '0;
      if (abort && (state_q != IDLE) && (state_q != FLUSH)) begin
        // Partial results stay visible; engines get a clean reset before idling
        state_q   <= FLUSH;
        eng_rst_q <= 1'b1;
        hold_q    <= HOLD_INIT;
      end else begin
        case (state_q)
          IDLE: begin
            eng_rst_q <= 1'b0;
            if (batch_start) begin
              results_q      <= '0;
              timeout_mask_q <= '0;
              turn_count_q   <= '0;
              idx_q          <= '0;
              busy_q         <= 1'b1;
              eng_rst_q      <= 1'b1;
              hold_q         <= HOLD_INIT;
              state_q        <= ENG_RST;
            end
          end
          ENG_RST: begin
            if (hold_q == '0) begin
              eng_rst_q          <= 1'b0;
              eng_start_q[idx_q] <= 1'b1;
              state_q            <= LAUNCH;
            end else begin
              hold_q <= hold_q - RST_HOLD_W'(1);
            end
          end
          LAUNCH: begin
            // Start pulse self-clears via the default above
            state_q <= WAIT;
          end
          WAIT: begin
            // A done arriving with the timeout still counts as a valid result
            if (eng_done[idx_q]) begin
              results_q[idx_q] <= (eng_class[idx_q] == CLASS_TURN) ? CLASS_TURN : CLASS_STRAIGHT;
              if (eng_class[idx_q] == CLASS_TURN) begin
                turn_count_q <= turn_count_q + TC_W'(1);
              end
              state_q <= NEXT;
            end else if (wd_expired) begin
              timeout_mask_q[idx_q] <= 1'b1;
              results_q[idx_q]      <= CLASS_STRAIGHT;
              state_q               <= NEXT;
            end
          end
          NEXT: begin
            if (idx_q == LAST_IDX) begin
              idx_q        <= '0;
              batch_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              idx_q     <= idx_q + IDX_W'(1);
              eng_rst_q <= 1'b1;
              hold_q    <= HOLD_INIT;
              state_q   <= ENG_RST;
            end
          end
          FLUSH: begin
            if (hold_q == '0) begin
              eng_rst_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              hold_q <= hold_q - RST_HOLD_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign eng_rst      = eng_rst_q;
  assign eng_start    = eng_start_q;
  assign busy         = busy_q;
  assign batch_done   = batch_done_q;
  assign results      = results_q;
  assign timeout_mask = timeout_mask_q;
  assign turn_count   = turn_count_q;

endmodule

// File: tb/tb_snn_batch_scheduler.sv
// Directed bench for snn_batch_scheduler: two instances (long and short timeout) with engine models.
// Latency: engine models raise done a programmable number of cycles after their start pulse.
// Backpressure: n/a.
`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_snn_batch_scheduler;

  localparam int N = 20;

  logic clk;
  logic rst_n;

  logic          bs_a, ab_a, eng_rst_a, busy_a, bd_a;
  logic [N-1:0]  eng_start_a, eng_done_a, cls_a, results_a, tmask_a;
  logic [4:0]    tc_a;

  logic          bs_b, ab_b, eng_rst_b, busy_b, bd_b;
  logic [N-1:0]  eng_start_b, eng_done_b, cls_b, results_b, tmask_b;
  logic [4:0]    tc_b;

  int checks   = 0;
  int failures = 0;

  // Engine model state
  int del_a[N];
  int del_b[N];
  bit act_a, act_b;
  int cnt_a, cnt_b, cur_a, cur_b;

  // Monitors
  int bd_cnt_a = 0;
  int bd_cnt_b = 0;
  int onehot_bad = 0;
  int launch_log[$];

  snn_batch_scheduler #(.NUM_ENGINES(N), .RST_HOLD(2), .TIMEOUT(65535)) dut_a (
    .clk(clk), .rst_n(rst_n), .batch_start(bs_a), .abort(ab_a),
    .eng_rst(eng_rst_a), .eng_start(eng_start_a), .eng_done(eng_done_a),
    .eng_class(cls_a), .busy(busy_a), .batch_done(bd_a), .results(results_a),
    .timeout_mask(tmask_a), .turn_count(tc_a)
  );

  snn_batch_scheduler #(.NUM_ENGINES(N), .RST_HOLD(2), .TIMEOUT(50)) dut_b (
    .clk(clk), .rst_n(rst_n), .batch_start(bs_b), .abort(ab_b),
    .eng_rst(eng_rst_b), .eng_start(eng_start_b), .eng_done(eng_done_b),
    .eng_class(cls_b), .busy(busy_b), .batch_done(bd_b), .results(results_b),
    .timeout_mask(tmask_b), .turn_count(tc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model A: done level rises del_a[k] negedges after the start pulse, cleared by eng_rst
  always @(negedge clk) begin
    if (!rst_n || eng_rst_a) begin
      act_a = 1'b0;
      eng_done_a = '0;
    end else if (eng_start_a != '0) begin
      act_a = 1'b1;
      cnt_a = 0;
      eng_done_a = '0;
      for (int k = 0; k < N; k++) if (eng_start_a[k]) cur_a = k;
    end else if (act_a) begin
      cnt_a++;
      if (cnt_a >= del_a[cur_a]) eng_done_a[cur_a] = 1'b1;
    end
  end

  // Engine model B
  always @(negedge clk) begin
    if (!rst_n || eng_rst_b) begin
      act_b = 1'b0;
      eng_done_b = '0;
    end else if (eng_start_b != '0) begin
      act_b = 1'b1;
      cnt_b = 0;
      eng_done_b = '0;
      for (int k = 0; k < N; k++) if (eng_start_b[k]) cur_b = k;
    end else if (act_b) begin
      cnt_b++;
      if (cnt_b >= del_b[cur_b]) eng_done_b[cur_b] = 1'b1;
    end
  end

  // Launch and batch_done monitors
  always @(negedge clk) begin
    if (bd_a) bd_cnt_a++;
    if (bd_b) bd_cnt_b++;
    if (eng_start_a != '0) begin
      if (!$onehot(eng_start_a)) onehot_bad++;
      for (int k = 0; k < N; k++) if (eng_start_a[k]) launch_log.push_back(k);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a();
    @(negedge clk); bs_a = 1'b1;
    @(negedge clk); bs_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk); bs_b = 1'b1;
    @(negedge clk); bs_b = 1'b0;
  endtask

  task automatic wait_bd_a(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bd_a) begin seen = 1'b1; break; end
    end
  endtask

  task automatic wait_bd_b(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bd_b) begin seen = 1'b1; break; end
    end
  endtask

  task automatic wait_start_a(input int k, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (eng_start_a[k]) begin seen = 1'b1; break; end
    end
  endtask

  initial begin
    bit seen;
    int base;
    int bad;

    bs_a = 1'b0; ab_a = 1'b0; bs_b = 1'b0; ab_b = 1'b0;
    cls_a = '0; cls_b = '0;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin del_a[k] = 100; del_b[k] = 10; end

    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    `CHK("rst_eng_rst", eng_rst_a, 1);
    `CHK("rst_eng_start", eng_start_a, 0);
    `CHK("rst_busy", busy_a, 0);
    `CHK("rst_batch_done", bd_a, 0);
    `CHK("rst_results", results_a, 0);
    `CHK("rst_tmask", tmask_a, 0);
    `CHK("rst_turn_count", tc_a, 0);
    `CHK("rst_b_eng_rst", eng_rst_b, 1);
    repeat (2) @(negedge clk);
    `CHK("rst_held_eng_rst", eng_rst_a, 1);
    rst_n = 1'b1;
    @(negedge clk);
    `CHK("release_eng_rst", eng_rst_a, 0);
    `CHK("release_busy", busy_a, 0);

    // Full batch, done after 100 cycles, classes alternating 0/1, with a mid-batch re-start
    cls_a = 20'hAAAAA;
    base = launch_log.size();
    pulse_a();
    `CHK("acc_busy", busy_a, 1);
    `CHK("acc_eng_rst_c1", eng_rst_a, 1);
    `CHK("acc_eng_start_c1", eng_start_a, 0);
    @(negedge clk);
    `CHK("acc_eng_rst_c2", eng_rst_a, 1);
    @(negedge clk);
    `CHK("launch0_start", eng_start_a, 20'h00001);
    `CHK("launch0_eng_rst", eng_rst_a, 0);
    @(negedge clk);
    `CHK("launch0_start_cleared", eng_start_a, 0);
    repeat (300) @(negedge clk);
    `CHK("mid_busy", busy_a, 1);
    pulse_a();
    wait_bd_a(4000, seen);
    `CHK("b34_done_seen", seen, 1);
    `CHK("b34_results", results_a, 20'hAAAAA);
    `CHK("b34_turn_count", tc_a, 10);
    `CHK("b34_tmask", tmask_a, 0);
    `CHK("b34_busy_low", busy_a, 0);
    @(negedge clk);
    `CHK("b34_done_pulse_end", bd_a, 0);
    repeat (20) @(negedge clk);
    `CHK("b34_done_count", bd_cnt_a, 1);
    `CHK("b34_results_stable", results_a, 20'hAAAAA);
    `CHK("b34_tc_stable", tc_a, 10);
    `CHK("b34_launches", launch_log.size() - base, 20);
    bad = 0;
    for (int i = 0; i < 20 && (base + i) < launch_log.size(); i++)
      if (launch_log[base + i] != i) bad++;
    `CHK("b34_idx_sequence", bad, 0);
    `CHK("b34_onehot", onehot_bad, 0);

    // Abort during WAIT of engine 5
    cls_a = 20'h00015;
    pulse_a();
    `CHK("b36_acc_results_clear", results_a, 0);
    `CHK("b36_acc_tc_clear", tc_a, 0);
    wait_start_a(5, 3000, seen);
    `CHK("b36_eng5_launched", seen, 1);
    repeat (10) @(negedge clk);
    ab_a = 1'b1;
    @(negedge clk);
    ab_a = 1'b0;
    `CHK("flush_c1_eng_rst", eng_rst_a, 1);
    `CHK("flush_c1_busy", busy_a, 1);
    @(negedge clk);
    `CHK("flush_c2_eng_rst", eng_rst_a, 1);
    @(negedge clk);
    `CHK("flush_end_eng_rst", eng_rst_a, 0);
    `CHK("flush_end_busy", busy_a, 0);
    `CHK("b36_partial_results", results_a, 20'h00015);
    `CHK("b36_partial_tc", tc_a, 3);
    `CHK("b36_tmask", tmask_a, 0);
    repeat (20) @(negedge clk);
    `CHK("b36_no_batch_done", bd_cnt_a, 1);

    // Short timeout: engine 3 never finishes
    cls_b = 20'hFFFFF;
    del_b[3] = 1000000;
    pulse_b();
    wait_bd_b(3000, seen);
    `CHK("b35_done_seen", seen, 1);
    `CHK("b35_tmask", tmask_b, 20'h00008);
    `CHK("b35_results", results_b, 20'hFFFF7);
    `CHK("b35_turn_count", tc_b, 19);

    // Done arrives in the same cycle the timeout expires on engine 0
    cls_b = 20'h00001;
    del_b[3] = 10;
    del_b[0] = 51;
    pulse_b();
    wait_bd_b(3000, seen);
    `CHK("b38_done_seen", seen, 1);
    `CHK("b38_results", results_b, 20'h00001);
    `CHK("b38_tmask", tmask_b, 0);
    `CHK("b38_turn_count", tc_b, 1);
    repeat (5) @(negedge clk);
    `CHK("b38_done_count", bd_cnt_b, 2);

    // Reset asserted while waiting on engine 2
    pulse_a();
    wait_start_a(2, 3000, seen);
    `CHK("b39_eng2_launched", seen, 1);
    repeat (5) @(negedge clk);
    `CHK("b39_pre_results", results_a, 20'h00001);
    `CHK("b39_pre_busy", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    `CHK("b39_eng_rst", eng_rst_a, 1);
    `CHK("b39_eng_start", eng_start_a, 0);
    `CHK("b39_busy", busy_a, 0);
    `CHK("b39_batch_done", bd_a, 0);
    `CHK("b39_results", results_a, 0);
    `CHK("b39_tmask", tmask_a, 0);
    `CHK("b39_turn_count", tc_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    `CHK("b39_post_idle_busy", busy_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_batch_scheduler.md
SNN_BATCH_SCHEDULER -- requirements
Module: snn_batch_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENGINES, default 20: number of snn_fc_top engine instances sequenced (1..64).
REQ-002 SHALL have parameter RST_HOLD, default 2: cycles eng_rst is held high before each launch (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 65535: maximum cycles to wait for an engine done after its start (1..2^20-1).
REQ-004 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port batch_start, input, 1: one-cycle request to run a batch over all engines.
REQ-007 SHALL have port abort, input, 1: terminates the batch in progress.
REQ-008 SHALL have port eng_rst, output, 1: active-high reset driven to all engines.
REQ-009 SHALL have port eng_start, output, NUM_ENGINES: one-hot start pulse per engine.
REQ-010 SHALL have port eng_done, input, NUM_ENGINES: per-engine done level.
REQ-011 SHALL have port eng_class, input, NUM_ENGINES: per-engine predicted_class (0 straight, 1 turning).
REQ-012 SHALL have port busy, output, 1: high from batch acceptance until return to IDLE.
REQ-013 SHALL have port batch_done, output, 1: one-cycle pulse on batch completion (not on abort).
REQ-014 SHALL have port results, output, NUM_ENGINES: captured class per engine.
REQ-015 SHALL have port timeout_mask, output, NUM_ENGINES: engine timed out.
REQ-016 SHALL have port turn_count, output, $clog2(NUM_ENGINES+1): number of results bits equal to 1.

Function
REQ-017 SHALL implement FSM states IDLE, ENG_RST, LAUNCH, WAIT, NEXT, FLUSH.
REQ-018 SHALL, in IDLE, accept batch_start: clear results, timeout_mask, turn_count, set idx=0, enter ENG_RST; busy rises the next cycle.
REQ-019 SHALL ignore batch_start while busy.
REQ-020 SHALL, in ENG_RST, drive eng_rst=1 for exactly RST_HOLD cycles, then enter LAUNCH.
REQ-021 SHALL, in LAUNCH, assert eng_start[idx] for exactly one cycle, zero the timeout counter, and enter WAIT; all other eng_start bits stay 0.
REQ-022 SHALL, in WAIT, sample only eng_done[idx]; on 1, capture eng_class[idx] into results[idx], add it to turn_count, and enter NEXT.
REQ-023 SHALL, in WAIT, on the counter reaching TIMEOUT with done low, set timeout_mask[idx], leave results[idx]=0, and enter NEXT.
REQ-024 SHALL treat done and timeout in the same cycle as done (result captured, no timeout flag).
REQ-025 SHALL, in NEXT, increment idx; if idx was NUM_ENGINES-1, pulse batch_done for one cycle and enter IDLE; otherwise enter ENG_RST.
REQ-026 SHALL hold results, timeout_mask, turn_count stable after batch_done until the next accepted batch_start.
REQ-027 SHALL, on abort in any non-IDLE state, enter FLUSH, drive eng_rst=1 for RST_HOLD cycles, then enter IDLE without batch_done; partial results remain readable.
REQ-028 SHALL give abort priority over done, timeout, and state transitions in the same cycle; abort in IDLE is ignored.
REQ-029 SHALL size the timeout counter to $clog2(TIMEOUT+1) bits, saturating, never wrapping.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force state=IDLE, idx=0, eng_rst=1, eng_start=0, busy=0, batch_done=0, results=0, timeout_mask=0, turn_count=0.
REQ-031 SHALL release eng_rst to 0 on the first clock after rst_n deasserts while in IDLE.

Structure
REQ-032 SHALL place the FSM state enum and class encodings (CLASS_STRAIGHT=0, CLASS_TURN=1) in shared package snn_pkg.
REQ-033 SHALL implement the per-engine wait/timeout counter as sub-module snn_watchdog (load, enable, expired).

Verification
REQ-034 SHALL cover a 20-engine batch with done after 100 cycles per engine and classes alternating 0/1: results=0xAAAAA, turn_count=10, timeout_mask=0, one batch_done pulse.
REQ-035 SHALL cover TIMEOUT=50 with engine 3 never asserting done: timeout_mask=0x00008, results[3]=0, batch completes.
REQ-036 SHALL cover abort asserted in WAIT of engine 5: FLUSH holds eng_rst=1 for 2 cycles, IDLE follows, no batch_done, results[4:0] retained.
REQ-037 SHALL cover batch_start re-pulsed mid-batch: ignored, idx sequence 0..19 unbroken, exactly one batch_done.
REQ-038 SHALL cover done and timeout coinciding on engine 0 with class 1: results[0]=1, timeout_mask[0]=0.
REQ-039 SHALL cover rst_n asserted in WAIT: all outputs reach REQ-030 values without a clock edge.
